// File: rtl/sram_bus_master_pkg.sv
// Shared constants for the SRAM bus initiator: FSM state encoding and default widths.
// No logic lives here.
package sram_bus_master_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

endpackage

// File: rtl/sram_bus_master.sv
// Single-beat cs/we/oe SRAM initiator with setup, access and recover phases.
// Latency: read data valid WAIT_CYCLES+2 cycles after acceptance; one transaction per WAIT_CYCLES+3.
// Backpressure: req_ready is high only in IDLE; request inputs are ignored while busy.
module sram_bus_master
    import sram_bus_master_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    localparam int              WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int              CNT_W    = $clog2(WAIT_EFF + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    rsp_valid_q;
    logic                    drive_en_q;
    logic                    accept;
    logic                    access_done;

    assign accept      = req_valid && (state_q == ST_IDLE);
    assign access_done = (state_q == ST_ACCESS) && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (req_valid) state_d = ST_SETUP;
            ST_SETUP:   state_d = ST_ACCESS;
            ST_ACCESS:  if (cnt_q == '0) state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Driver enable is registered from the next state so the bus is released
    // on the same edge that leaves RECOVER and is never on while oe is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            drive_en_q  <= 1'b0;
        end else begin
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == ST_SETUP) begin
                cnt_q <= CNT_LOAD;
            end else if ((state_q == ST_ACCESS) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            drive_en_q  <= wr_q && ((state_d == ST_ACCESS) || (state_d == ST_RECOVER));
            rsp_valid_q <= access_done && !wr_q;
            if (access_done && !wr_q) begin
                rdata_q <= mem_data;
            end
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign mem_address = addr_q;
    assign mem_cs      = (state_q == ST_SETUP) || (state_q == ST_ACCESS) ||
                         ((state_q == ST_RECOVER) && wr_q);
    assign mem_we      = (state_q == ST_ACCESS) && wr_q;
    assign mem_oe      = (state_q == ST_ACCESS) && !wr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign mem_data    = drive_en_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule
